// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: multi-cycle instruction fetch and program-counter stage that
// sits directly upstream of the control decoder.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr   fetch request and address (imem_addr always equals pc)
//   imem_ack/imem_rdata  memory response; the word is captured on the ack cycle
//   instr/opcode/funct   latched instruction and decoder fields
//   instr_valid          instr holds an instruction awaiting execution
//   exec_done            datapath finished; commit next_pc on this cycle
//   branch/zero/jump/jr  control-flow selection, sampled only on exec_done
//   rs_data              JR target from the register file
//   pc/pc_plus4          current PC and its link value
//   addr_err             sticky flag, set by a JR to a misaligned target
//
// Optional build macro FETCH_RETIRE_COUNT_EN adds the retire_count and
// fetch_stall_count outputs. With the macro undefined, neither port exists.
module fetch_pc_unit #(
   parameter int                     PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   parameter int                     INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [5:0]             opcode,
   output logic [5:0]             funct,
   output logic                   instr_valid,
   input  logic                   exec_done,
   input  logic                   branch,
   input  logic                   zero,
   input  logic                   jump,
   input  logic                   jr,
   input  logic [PC_WIDTH-1:0]    rs_data,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [PC_WIDTH-1:0]    pc_plus4,
`ifdef FETCH_RETIRE_COUNT_EN
   output logic [31:0]            retire_count,
   output logic [31:0]            fetch_stall_count,
`endif
   output logic                   addr_err
);

   typedef enum logic {S_REQ, S_EXEC} state_t;

   state_t                   state_q, state_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
   logic                     req_q, req_d;
   logic                     addr_err_q, addr_err_d;
   logic [PC_WIDTH-1:0]      next_pc;
   logic [PC_WIDTH-1:0]      br_off;

   // imem_req is registered so that it is low throughout reset and rises in
   // the first clock after release. An ack is accepted only while the request
   // is actually presented, which also discards a stale ack arriving in the
   // cycle right after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         req_q      <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         req_q      <= req_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_comb begin
      pc_plus4 = pc_q + PC_WIDTH'(4);
      br_off   = {{(PC_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};
      if (jr)
         next_pc = {rs_data[PC_WIDTH-1:2], 2'b00};
      else if (jump)
         next_pc = {pc_plus4[PC_WIDTH-1:28], instr_q[25:0], 2'b00};
      else if (branch && zero)
         next_pc = pc_plus4 + br_off;
      else
         next_pc = pc_plus4;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      req_d      = req_q;
      addr_err_d = addr_err_q;
      case (state_q)
         S_REQ: begin
            if (req_q && imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
               req_d   = 1'b0;
            end else begin
               req_d   = 1'b1;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               pc_d    = next_pc;
               state_d = S_REQ;
               req_d   = 1'b1;
               if (jr && (rs_data[1:0] != 2'b00))
                  addr_err_d = 1'b1;
            end
         end
         default: begin
            state_d = S_REQ;
            req_d   = 1'b0;
         end
      endcase
   end

`ifdef FETCH_RETIRE_COUNT_EN
   logic [31:0] retire_q, retire_d;
   logic [31:0] stall_q, stall_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q <= '0;
         stall_q  <= '0;
      end else begin
         retire_q <= retire_d;
         stall_q  <= stall_d;
      end
   end

   always_comb begin
      retire_d = retire_q;
      stall_d  = stall_q;
      if (state_q == S_EXEC && exec_done)
         retire_d = retire_q + 32'd1;
      // Only cycles with the request actually presented count as stalls.
      if (state_q == S_REQ && req_q && !imem_ack)
         stall_d = stall_q + 32'd1;
   end

   assign retire_count      = retire_q;
   assign fetch_stall_count = stall_q;
`endif

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign instr_valid = (state_q == S_EXEC);
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;
   logic        jr = 1'b0;
   logic [31:0] rs_data = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        addr_err;
`ifdef FETCH_RETIRE_COUNT_EN
   logic [31:0] retire_count;
   logic [31:0] fetch_stall_count;
`endif

   int n_pass = 0;
   int n_total = 0;

   // reference state
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_instr = 32'h0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .INSTR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
      .exec_done(exec_done), .branch(branch), .zero(zero), .jump(jump), .jr(jr),
      .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4),
`ifdef FETCH_RETIRE_COUNT_EN
      .retire_count(retire_count), .fetch_stall_count(fetch_stall_count),
`endif
      .addr_err(addr_err)
   );

   // Architectural next-PC rule, written with plain integer arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic b, input logic z, input logic j,
                                            input logic r, input logic [31:0] rs);
      longint seq, off;
      seq = (longint'(cur) + 4) % 64'h1_0000_0000;
      if (r) return rs - (rs % 4);
      if (j) return 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(ins % 32'h0400_0000) * 4);
      if (b && z) begin
         off = longint'(ins % 32'h1_0000);
         if (off >= 32768) off = off - 65536;
         return 32'((seq + off * 4) % 64'h1_0000_0000 + 64'h1_0000_0000);
      end
      return 32'(seq);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0;
      step(); step();
      rst = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] word, input int waits);
      int n = 0;
      while (!imem_req && n < 8) begin step(); n++; end
      n_total++; if (imem_req !== 1'b1) $display("FAIL fetch_req_rise got=%b exp=1", imem_req); else n_pass++;
      n_total++; if (imem_addr !== m_pc) $display("FAIL fetch_addr got=%h exp=%h", imem_addr, m_pc); else n_pass++;
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0; imem_rdata = $urandom;
         step();
         n_total++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0)
            $display("FAIL fetch_wait req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, m_pc);
         else n_pass++;
      end
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0; imem_rdata = $urandom;
      m_instr = word;
      n_total++; if (instr !== m_instr) $display("FAIL fetch_instr got=%h exp=%h", instr, m_instr); else n_pass++;
      n_total++;
      if (opcode !== m_instr[31:26] || funct !== m_instr[5:0])
         $display("FAIL fetch_fields got=%h/%h exp=%h/%h", opcode, funct, m_instr[31:26], m_instr[5:0]);
      else n_pass++;
      n_total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0)
         $display("FAIL fetch_exec valid=%b req=%b exp valid=1 req=0", instr_valid, imem_req);
      else n_pass++;
   endtask

   task automatic exec(input logic b, input logic z, input logic j, input logic r,
                       input logic [31:0] rs, input int idle);
      logic [31:0] exp_pc;
      for (int i = 0; i < idle; i++) begin
         exec_done = 1'b0; imem_ack = 1'($urandom); imem_rdata = $urandom;
         branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom); jr = 1'($urandom);
         rs_data = $urandom;
         step();
         n_total++;
         if (pc !== m_pc || instr !== m_instr || instr_valid !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL exec_hold pc=%h instr=%h valid=%b req=%b exp pc=%h instr=%h valid=1 req=0",
                     pc, instr, instr_valid, imem_req, m_pc, m_instr);
         else n_pass++;
      end
      imem_ack = 1'b0;
      n_total++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, m_pc + 32'd4); else n_pass++;
      exp_pc = ref_next(m_pc, m_instr, b, z, j, r, rs);
      if (r && (rs % 4) != 0) m_err = 1'b1;
      branch = b; zero = z; jump = j; jr = r; rs_data = rs; exec_done = 1'b1;
      step();
      exec_done = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0;
      m_pc = exp_pc;
      n_total++; if (pc !== m_pc) $display("FAIL exec_pc got=%h exp=%h", pc, m_pc); else n_pass++;
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0)
         $display("FAIL exec_rereq req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, m_pc);
      else n_pass++;
      n_total++; if (addr_err !== m_err) $display("FAIL addr_err got=%b exp=%b", addr_err, m_err); else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step(); step();
      n_total++;
      if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || addr_err !== 1'b0)
         $display("FAIL reset_state pc=%h instr=%h valid=%b req=%b err=%b exp all zero", pc, instr, instr_valid, imem_req, addr_err);
      else n_pass++;
      imem_ack = 1'b0;
      rst = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
      n_total++; if (imem_req !== 1'b0) $display("FAIL reset_release_req got=%b exp=0", imem_req); else n_pass++;
      step();
      n_total++; if (imem_req !== 1'b1) $display("FAIL first_req got=%b exp=1", imem_req); else n_pass++;
   endtask

   task automatic test_first_fetch();
      fetch(32'h0000_0020, 3);
      n_total++; if (funct !== 6'h20 || opcode !== 6'h00) $display("FAIL first_fields got=%h/%h exp=00/20", opcode, funct); else n_pass++;
   endtask

   task automatic test_sequential();
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1);
      fetch($urandom, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
      n_total++; if (imem_addr !== 32'h0000_0104) $display("FAIL seq_addr got=%h exp=00000104", imem_addr); else n_pass++;
   endtask

   task automatic test_branch();
      fetch($urandom, 1);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 0);
      fetch(32'h1000_FFFE, 0);
      exec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2);
      n_total++; if (pc !== 32'h0000_01FC) $display("FAIL branch_taken got=%h exp=000001fc", pc); else n_pass++;
      fetch($urandom, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 0);
      fetch(32'h1000_FFFE, 0);
      exec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
      n_total++; if (pc !== 32'h0000_0204) $display("FAIL branch_not_taken got=%h exp=00000204", pc); else n_pass++;
   endtask

   task automatic test_jump();
      fetch($urandom, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0010, 0);
      fetch(32'h0800_0040, 1);
      exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
      n_total++; if (pc !== 32'h4000_0100) $display("FAIL jump_pc got=%h exp=40000100", pc); else n_pass++;
      fetch($urandom, 0);
      exec(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1003, 0);
      n_total++; if (pc !== 32'h0000_1000 || addr_err !== 1'b1) $display("FAIL jr_misaligned pc=%h err=%b exp 00001000/1", pc, addr_err); else n_pass++;
      fetch($urandom, 2);
      exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
      n_total++; if (addr_err !== 1'b1) $display("FAIL addr_err_sticky got=%b exp=1", addr_err); else n_pass++;
   endtask

   task automatic test_wrap();
      fetch($urandom, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
      fetch(32'h0000_0000, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
      n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h exp=00000000", pc); else n_pass++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         fetch($urandom, int'($urandom_range(0, 3)));
         exec(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom, int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      fetch($urandom, 0);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 0);
      while (!imem_req && n < 8) begin step(); n++; end
      imem_ack = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      n_total++; if (imem_req !== 1'b0 || pc !== 32'h0) $display("FAIL mid_reset_async req=%b pc=%h exp 0/00000000", imem_req, pc); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      step();
      rst = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
      step();
      imem_ack = 1'b0;
      n_total++;
      if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_addr !== 32'h0)
         $display("FAIL late_ack instr=%h valid=%b addr=%h exp 00000000/0/00000000", instr, instr_valid, imem_addr);
      else n_pass++;
      fetch(32'h0000_0020, 1);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         fetch($urandom, 0);
         exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
      end
   endtask

`ifdef FETCH_RETIRE_COUNT_EN
   task automatic test_counters();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         fetch($urandom, 2);
         exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
      end
      n_total++; if (retire_count !== 32'd5) $display("FAIL retire_count got=%0d exp=5", retire_count); else n_pass++;
      n_total++; if (fetch_stall_count !== 32'd10) $display("FAIL fetch_stall_count got=%0d exp=10", fetch_stall_count); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_first_fetch();
      test_sequential();
      test_branch();
      test_jump();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef FETCH_RETIRE_COUNT_EN
      test_counters();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Multi-cycle instruction fetch and program-counter stage directly upstream of the control decoder.
- Holds the PC and requests instructions over a req/ack handshake to instruction memory.
- Latches the returned word, presents opcode[31:26] and funct[5:0] to the control decoder, and holds them stable until the datapath signals completion.
- On completion, computes the next PC from the decoder's Branch/JUMP/JR outputs and the ALU zero flag.

Parameters:
- PC_WIDTH, 32, width of PC and instruction address.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- INSTR_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address; equals pc.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  INSTR_WIDTH  fetched instruction word.
- instr  output  INSTR_WIDTH  latched instruction.
- opcode  output  6  instr[31:26], to control decoder.
- funct  output  6  instr[5:0], to control decoder.
- instr_valid  output  1  instr holds a valid instruction awaiting execution.
- exec_done  input  1  datapath finished the current instruction; commit next PC.
- branch  input  1  decoder Branch.
- zero  input  1  ALU zero flag.
- jump  input  1  decoder JUMP.
- jr  input  1  decoder JR.
- rs_data  input  PC_WIDTH  register-file rs value (JR target).
- pc  output  PC_WIDTH  current PC.
- pc_plus4  output  PC_WIDTH  pc+4 (link value).
- addr_err  output  1  sticky misaligned-JR flag.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, addr_err=0, state=S_REQ. Outputs are held while rst is high.
- State S_REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_addr stays stable while imem_req is high.
  - imem_ack=1: instr<=imem_rdata, go to S_EXEC; imem_req drops the next cycle.
  - First request is asserted in the first clock after rst deasserts.
- State S_EXEC:
  - instr_valid=1, imem_req=0; instr, opcode, funct and pc are held constant.
  - exec_done=1: pc<=next_pc, go to S_REQ.
  - Minimum fetch-to-next-request latency is 2 cycles (ack cycle, then exec_done cycle).
- next_pc, priority high to low:
  - jr: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, addr_err<=1 (sticky until reset).
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch&zero: pc_plus4 + (sign_extend(instr[15:0])<<2).
  - otherwise: pc_plus4.
  - Simultaneous jr/jump/branch follows this priority; no error is raised.
- Arithmetic: modulo 2^PC_WIDTH. pc=32'hFFFF_FFFC sequential wraps to 32'h0000_0000. Negative branch offsets wrap the same way.
- pc_plus4 = pc+4, combinational.
- Ignored events:
  - imem_ack outside S_REQ.
  - exec_done outside S_EXEC.
  - branch/jump/jr/zero/rs_data are sampled only on the exec_done cycle.
- Reset mid-operation: an in-flight request is abandoned. An ack arriving during or after reset for the old address is ignored (state is S_REQ with the new address).
- No branch delay slot.

Optional Feature:
- Macro FETCH_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count (32 bits), reset to 0.
  - Increments by 1 on each S_EXEC cycle with exec_done=1; wraps 32'hFFFF_FFFF->0.
  - Adds output fetch_stall_count (32 bits), reset to 0; increments on each S_REQ cycle with imem_ack=0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, imem_ack after 3 wait cycles with rdata=32'h0000_0020 -> imem_req high 4 cycles at addr 0, then instr=32'h20, funct=6'h20, opcode=0, instr_valid=1.
- Sequential: exec_done with no control flags at pc=0x100 -> pc=0x104, imem_req reasserted the next cycle with imem_addr=0x104.
- Branch at pc=0x200, instr[15:0]=16'hFFFE, branch=1, zero=1 -> pc=0x1FC. Same with zero=0 -> pc=0x204.
- Jump at pc=0x4000_0010, instr[25:0]=26'h0000040 -> pc=0x4000_0100. jr=1 and jump=1 with rs_data=0x1003 -> pc=0x1000, addr_err=1 and it stays 1.
- Wrap: pc=32'hFFFF_FFFC, sequential exec_done -> pc=0. Assert rst during S_REQ wait then send a late ack -> instr unchanged (0), imem_addr=RESET_PC.
- With FETCH_RETIRE_COUNT_EN: 5 instructions each with 2 wait cycles -> retire_count=5, fetch_stall_count=10.
